// File: rtl/alu_issuer.sv
// ---------------------------------------------------------------------------
// alu_issuer
//   Initiator side of the ALU operand/instruction interface. Requests arrive
//   over a valid/ready handshake. They are registered onto the a/b/instr
//   inputs of one alu instance. The alu output is captured two edges after
//   acceptance and is returned in order, together with the caller tag,
//   through a result FIFO.
//
// Parameters
//   DEPTH      result FIFO entries (power of 2, >= 2); also the cap on
//              FIFO + in-flight operations
//   TAG_W      request/result tag width
//
// Ports
//   c          clock, all state changes on posedge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle
//   req_op     ALU opcode (alu instr encoding)
//   req_a      operand a (65 bits)
//   req_b      operand b (65 bits)
//   req_tag    caller tag, returned unchanged
//   alu_a      to alu a
//   alu_b      to alu b
//   alu_instr  to alu instr (9'h080 = NOOP)
//   alu_out    from alu out
//   res_valid  result FIFO head valid
//   res_ready  consumer takes the head
//   res_data   head result (0 when res_err)
//   res_tag    head tag
//   res_err    head op was illegal or divide/modulo by zero
//   busy       any op in flight or queued
// ---------------------------------------------------------------------------
module alu_issuer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             c,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [8:0]       req_op,
   input  logic [64:0]      req_a,
   input  logic [64:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [64:0]      alu_a,
   output logic [64:0]      alu_b,
   output logic [8:0]       alu_instr,
   input  logic [64:0]      alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [64:0]      res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_err,
   output logic             busy
);

   localparam int         PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         OCC_W  = $clog2(DEPTH) + 1;
   localparam logic [8:0] NOOP   = 9'h080;
   localparam logic [8:0] OP_DIV = 9'h003;
   localparam logic [8:0] OP_MOD = 9'h004;

   // ALU input registers
   logic [64:0]      r_alu_a;
   logic [64:0]      r_alu_b;
   logic [8:0]       r_alu_instr;

   // Sideband pipeline: S1 = inputs on the alu, S2 = alu has latched them
   logic             r_s1_v;
   logic [TAG_W-1:0] r_s1_tag;
   logic             r_s1_err;
   logic             r_s2_v;
   logic [TAG_W-1:0] r_s2_tag;
   logic             r_s2_err;

   // Result FIFO
   logic [64:0]      r_mem_data [DEPTH];
   logic [TAG_W-1:0] r_mem_tag  [DEPTH];
   logic             r_mem_err  [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;

   logic             w_legal;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic [OCC_W-1:0] w_credit;
   logic [64:0]      w_push_data;

   // ------------------------------------------------------------------
   // Request side
   // ------------------------------------------------------------------
   assign w_legal = (req_op[8:4] == '0) &&
                    !(((req_op == OP_DIV) || (req_op == OP_MOD)) && (req_b == '0));

   // Credit covers queued results plus everything still in the pipeline,
   // so a push can never find the FIFO full without a matching pop.
   assign w_credit  = r_occ + OCC_W'(r_s1_v) + OCC_W'(r_s2_v);
   assign req_ready = rst_n && (w_credit < OCC_W'(DEPTH));
   assign w_accept  = req_valid && req_ready;

   // Stage S1: operands onto the alu. Illegal ops and idle cycles drive
   // NOOP; operands hold their last value when nothing legal is issued.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_instr <= NOOP;
         r_s1_v      <= 1'b0;
         r_s1_tag    <= '0;
         r_s1_err    <= 1'b0;
      end else begin
         r_s1_v      <= w_accept;
         r_alu_instr <= NOOP;
         if (w_accept) begin
            r_s1_tag <= req_tag;
            r_s1_err <= !w_legal;
            if (w_legal) begin
               r_alu_a     <= req_a;
               r_alu_b     <= req_b;
               r_alu_instr <= req_op;
            end
         end
      end
   end

   // Stage S2: alu latches its inputs on this edge; sideband follows.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v   <= 1'b0;
         r_s2_tag <= '0;
         r_s2_err <= 1'b0;
      end else begin
         r_s2_v   <= r_s1_v;
         r_s2_tag <= r_s1_tag;
         r_s2_err <= r_s1_err;
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_instr = r_alu_instr;

   // ------------------------------------------------------------------
   // Result FIFO
   // ------------------------------------------------------------------
   assign w_push      = r_s2_v;
   assign w_push_data = r_s2_err ? '0 : alu_out;
   assign res_valid   = (r_occ != '0);
   assign w_pop       = res_valid && res_ready;
   assign w_full      = (r_occ == OCC_W'(DEPTH));

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge c) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= w_push_data;
         r_mem_tag[r_wr_ptr]  <= r_s2_tag;
         r_mem_err[r_wr_ptr]  <= r_s2_err;
      end
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   assign res_data = res_valid ? r_mem_data[r_rd_ptr] : '0;
   assign res_tag  = res_valid ? r_mem_tag[r_rd_ptr]  : '0;
   assign res_err  = res_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

   assign busy = r_s1_v || r_s2_v || (r_occ != '0);

   // A push into a full FIFO without a simultaneous pop would drop a result.
   a_no_overflow: assert property (@(posedge c) disable iff (!rst_n)
                                   !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_alu_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_issuer
//   Scoreboard bench for alu_issuer. Accepted requests push their expected
//   result (computed from the opcode rules) into a queue; the monitor checks
//   handshake state, alu drive and the FIFO head every cycle on negedge.
//   A behavioural alu with one register stage sits on the alu_* ports.
// ---------------------------------------------------------------------------
module tb_alu_issuer;

   localparam int         DEPTH = 4;
   localparam int         TAG_W = 4;
   localparam logic [8:0] NOOP  = 9'h080;

   logic             c         = 1'b0;
   logic             rst_n     = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [8:0]       req_op    = '0;
   logic [64:0]      req_a     = '0;
   logic [64:0]      req_b     = '0;
   logic [TAG_W-1:0] req_tag   = '0;
   logic [64:0]      alu_a;
   logic [64:0]      alu_b;
   logic [8:0]       alu_instr;
   logic [64:0]      alu_out   = '0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [64:0]      res_data;
   logic [TAG_W-1:0] res_tag;
   logic             res_err;
   logic             busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [64:0]      data;
      logic [TAG_W-1:0] tag;
      logic             err;
      int               n;
   } exp_t;

   exp_t        sb[$];
   int          ncyc       = 0;
   logic [8:0]  exp_instr  = NOOP;
   logic        exp_ab_chk = 1'b0;
   logic [64:0] exp_a      = '0;
   logic [64:0] exp_b      = '0;

   always #5 c = ~c;

   alu_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .c         (c),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_instr (alu_instr),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_tag   (res_tag),
      .res_err   (res_err),
      .busy      (busy)
   );

   // Opcode meanings used by the bench alu and by the expected results.
   function automatic logic [64:0] ref_alu(logic [8:0] op, logic [64:0] a, logic [64:0] b);
      logic [64:0] r;
      case (op)
         9'h000:  r = a + b;
         9'h001:  r = a - b;
         9'h002:  r = a * b;
         9'h003:  r = (b == 0) ? 65'd0 : a / b;
         9'h004:  r = (b == 0) ? 65'd0 : a % b;
         9'h005:  r = a & b;
         9'h006:  r = a | b;
         9'h007:  r = a ^ b;
         9'h008:  r = a + 65'd1;
         9'h009:  r = a - 65'd1;
         9'h00A:  r = ~a;
         9'h00B:  r = a << b[5:0];
         9'h00C:  r = a >> b[5:0];
         9'h00D:  r = a;
         9'h00E:  r = b;
         9'h00F:  r = (a < b) ? 65'd1 : 65'd0;
         default: r = 65'd0;
      endcase
      return r;
   endfunction

   function automatic logic is_legal(logic [8:0] op, logic [64:0] b);
      if (op > 9'h00F) return 1'b0;
      if ((op == 9'h003 || op == 9'h004) && b == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [64:0] rnd65();
      logic [64:0] v;
      v = {1'($urandom), $urandom(), $urandom()};
      return v;
   endfunction

   // Behavioural alu: latches a/b/instr on each edge.
   always @(posedge c) alu_out <= ref_alu(alu_instr, alu_a, alu_b);

   task automatic check(string nm, logic [64:0] act, logic [64:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
      end
   endtask

   task automatic check_reset_outputs(string pfx);
      check({pfx, "_req_ready"}, 65'(req_ready), 65'd0);
      check({pfx, "_res_valid"}, 65'(res_valid), 65'd0);
      check({pfx, "_busy"},      65'(busy),      65'd0);
      check({pfx, "_alu_instr"}, 65'(alu_instr), 65'(NOOP));
      check({pfx, "_alu_a"},     alu_a,          65'd0);
      check({pfx, "_alu_b"},     alu_b,          65'd0);
      check({pfx, "_res_data"},  res_data,       65'd0);
      check({pfx, "_res_tag"},   65'(res_tag),   65'd0);
      check({pfx, "_res_err"},   65'(res_err),   65'd0);
   endtask

   // Monitor / scoreboard
   always @(negedge c) begin
      exp_t e;
      logic exp_valid;
      ncyc++;
      if (!rst_n) begin
         check_reset_outputs("rst");
         sb.delete();
         exp_instr  = NOOP;
         exp_ab_chk = 1'b0;
      end else begin
         check("alu_instr", 65'(alu_instr), 65'(exp_instr));
         if (exp_ab_chk) begin
            check("alu_a", alu_a, exp_a);
            check("alu_b", alu_b, exp_b);
         end
         check("req_ready", 65'(req_ready), 65'(sb.size() < DEPTH));
         check("busy",      65'(busy),      65'(sb.size() != 0));
         exp_valid = (sb.size() > 0) && (sb[0].n + 3 <= ncyc);
         check("res_valid", 65'(res_valid), 65'(exp_valid));
         if (exp_valid && res_valid) begin
            check("res_data", res_data,        sb[0].data);
            check("res_tag",  65'(res_tag),    65'(sb[0].tag));
            check("res_err",  65'(res_err),    65'(sb[0].err));
            if (res_ready) void'(sb.pop_front());
         end
         exp_instr  = NOOP;
         exp_ab_chk = 1'b0;
         if (req_valid && req_ready) begin
            e.err  = !is_legal(req_op, req_b);
            e.data = e.err ? 65'd0 : ref_alu(req_op, req_a, req_b);
            e.tag  = req_tag;
            e.n    = ncyc;
            sb.push_back(e);
            if (!e.err) begin
               exp_instr  = req_op;
               exp_a      = req_a;
               exp_b      = req_b;
               exp_ab_chk = 1'b1;
            end
         end
      end
   end

   task automatic idle(int n);
      repeat (n) begin
         @(posedge c);
         #1;
      end
   endtask

   task automatic wait_accept(int limit);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge c);
         acc = req_valid && req_ready;
         @(posedge c);
         #1;
         if (acc) break;
      end
      req_valid = 1'b0;
      check("accept_in_time", 65'(acc), 65'd1);
   endtask

   task automatic set_req(logic [8:0] op, logic [64:0] a, logic [64:0] b, logic [TAG_W-1:0] tag);
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      req_valid = 1'b1;
   endtask

   task automatic issue(logic [8:0] op, logic [64:0] a, logic [64:0] b, logic [TAG_W-1:0] tag);
      set_req(op, a, b, tag);
      wait_accept(50);
   endtask

   initial begin
      // Power-on reset
      idle(3);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      idle(2);

      // Single add
      issue(9'h000, 65'd5, 65'd7, 4'd3);
      idle(6);

      // Back-to-back sub, xor, inc
      issue(9'h001, 65'd10, 65'd4, 4'd1);
      issue(9'h007, 65'd6,  65'd3, 4'd2);
      issue(9'h008, 65'd9,  65'd0, 4'd3);
      idle(6);

      // Error ops between legal neighbours
      issue(9'h000, 65'd1, 65'd2, 4'd4);
      issue(9'h003, 65'd8, 65'd0, 4'd5);
      issue(NOOP,   65'd1, 65'd1, 4'd6);
      issue(9'h004, 65'd8, 65'd0, 4'd7);
      issue(9'h000, 65'd3, 65'd4, 4'd8);
      idle(6);

      // Backpressure: four accepts fill the credit, fifth waits
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(9'h000, 65'(i), 65'(100 + i), 4'(9 + i));
      set_req(9'h001, 65'd20, 65'd1, 4'd13);
      idle(6);
      res_ready = 1'b1;
      wait_accept(20);
      idle(8);

      // Random traffic with mid-stream resets and bursts of backpressure
      for (int i = 0; i < 3000; i++) begin
         if (i == 1000 || i == 2000) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async_rst");
            idle(2);
            rst_n = 1'b1;
         end
         if (i >= 500 && i < 800) res_ready = ($urandom_range(7) == 0);
         else                     res_ready = ($urandom_range(3) != 0);
         req_valid = ($urandom_range(2) != 0);
         req_op    = ($urandom_range(9) == 0) ? 9'($urandom) : 9'($urandom_range(15));
         req_a     = rnd65();
         req_b     = ($urandom_range(7) == 0) ? 65'd0 : rnd65();
         req_tag   = 4'($urandom);
         idle(1);
      end

      // Drain
      req_valid = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
      idle(2);
      check("drain_empty", 65'(sb.size()), 65'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
